// File: rtl/exu_div.sv
// Iterative RV64M divide/remainder unit: restoring division, one quotient bit per cycle.
// Stalls the pipeline while busy and presents a one-cycle result pulse.
module exu_div (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_flush,
    input  logic [2:0]  i_op,
    input  logic [63:0] i_src1,
    input  logic [63:0] i_src2,
    output logic        o_stall,
    output logic        o_valid,
    output logic [63:0] o_res
);
    localparam int unsigned CPU_WIDTH = 64;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                 state;
    logic [2:0]             op;
    logic [CPU_WIDTH-1:0]   quo;
    logic [CPU_WIDTH-1:0]   dvs;
    logic [CPU_WIDTH:0]     rem;
    logic [5:0]             cnt;
    logic                   q_neg;
    logic                   r_neg;
    logic [CPU_WIDTH-1:0]   res;

    logic                   is_signed;
    logic                   is_word;
    logic [CPU_WIDTH-1:0]   ext1;
    logic [CPU_WIDTH-1:0]   ext2;
    logic                   sgn1;
    logic                   sgn2;
    logic [CPU_WIDTH-1:0]   mag1;
    logic [CPU_WIDTH-1:0]   mag2;
    logic                   is_div0;
    logic                   is_ovf;
    logic [CPU_WIDTH-1:0]   spec_raw;
    logic [CPU_WIDTH-1:0]   spec_res;

    // Operand conditioning and special-case detection for the incoming op
    always_comb begin
        is_signed = ~i_op[0];
        is_word   = i_op[2];
        ext1      = '0;
        ext2      = '0;
        sgn1      = 1'b0;
        sgn2      = 1'b0;
        mag1      = '0;
        mag2      = '0;
        if (is_word) begin
            ext1 = is_signed ? {{32{i_src1[31]}}, i_src1[31:0]} : {32'b0, i_src1[31:0]};
            ext2 = is_signed ? {{32{i_src2[31]}}, i_src2[31:0]} : {32'b0, i_src2[31:0]};
            sgn1 = is_signed & i_src1[31];
            sgn2 = is_signed & i_src2[31];
            // Word dividend sits in the upper half so 32 shifts bring it through rem
            mag1 = {(sgn1 ? 32'(-i_src1[31:0]) : i_src1[31:0]), 32'b0};
            mag2 = {32'b0, (sgn2 ? 32'(-i_src2[31:0]) : i_src2[31:0])};
        end else begin
            ext1 = i_src1;
            ext2 = i_src2;
            sgn1 = is_signed & i_src1[63];
            sgn2 = is_signed & i_src2[63];
            mag1 = sgn1 ? -i_src1 : i_src1;
            mag2 = sgn2 ? -i_src2 : i_src2;
        end
        is_div0 = (ext2 == '0);
        is_ovf  = is_signed && (ext2 == '1) &&
                  (ext1 == (is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        spec_raw = '0;
        if (is_div0)
            spec_raw = i_op[1] ? ext1 : '1;
        else if (is_ovf)
            spec_raw = i_op[1] ? '0 : ext1;
        spec_res = is_word ? {{32{spec_raw[31]}}, spec_raw[31:0]} : spec_raw;
    end

    logic [CPU_WIDTH:0]     shifted;
    logic                   ge;
    logic [CPU_WIDTH:0]     diff;

    always_comb begin
        shifted = {rem[CPU_WIDTH-1:0], quo[CPU_WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        ge      = (shifted >= {1'b0, dvs});
    end

    logic [CPU_WIDTH-1:0]   q_fix;
    logic [CPU_WIDTH-1:0]   r_fix;
    logic [CPU_WIDTH-1:0]   sel;
    logic [CPU_WIDTH-1:0]   fix_res;

    always_comb begin
        q_fix   = q_neg ? -quo : quo;
        r_fix   = r_neg ? -rem[CPU_WIDTH-1:0] : rem[CPU_WIDTH-1:0];
        sel     = op[1] ? r_fix : q_fix;
        fix_res = op[2] ? {{32{sel[31]}}, sel[31:0]} : sel;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            op    <= '0;
            quo   <= '0;
            dvs   <= '0;
            rem   <= '0;
            cnt   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            res   <= '0;
        end else if (i_flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        op    <= i_op;
                        quo   <= mag1;
                        dvs   <= mag2;
                        rem   <= '0;
                        q_neg <= sgn1 ^ sgn2;
                        r_neg <= sgn1;
                        cnt   <= is_word ? 6'd31 : 6'd63;
                        if (is_div0 || is_ovf) begin
                            res   <= spec_res;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= ge ? diff : shifted;
                    quo <= {quo[CPU_WIDTH-2:0], ge};
                    if (cnt == '0)
                        state <= FIX;
                    else
                        cnt <= cnt - 6'd1;
                end
                FIX: begin
                    res   <= fix_res;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_stall = ((state == IDLE) && i_start) || (state == CALC) || (state == FIX);
    assign o_valid = (state == DONE);
    assign o_res   = res;
endmodule

// File: tb/tb_exu_div.sv
// Directed-vector bench for exu_div with an arithmetic reference model and a per-cycle result monitor.
module tb_exu_div;
    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic        i_flush;
    logic [2:0]  i_op;
    logic [63:0] i_src1;
    logic [63:0] i_src2;
    logic        o_stall;
    logic        o_valid;
    logic [63:0] o_res;

    int          total;
    int          passed;
    logic        pending;
    logic [63:0] model_res;

    localparam logic [2:0] OP_DIV   = 3'b000;
    localparam logic [2:0] OP_DIVU  = 3'b001;
    localparam logic [2:0] OP_REM   = 3'b010;
    localparam logic [2:0] OP_REMU  = 3'b011;
    localparam logic [2:0] OP_DIVW  = 3'b100;
    localparam logic [2:0] OP_DIVUW = 3'b101;
    localparam logic [2:0] OP_REMW  = 3'b110;

    exu_div dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_flush (i_flush),
        .i_op    (i_op),
        .i_src1  (i_src1),
        .i_src2  (i_src2),
        .o_stall (o_stall),
        .o_valid (o_valid),
        .o_res   (o_res)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: RISC-V M-extension semantics using native division
    function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [31:0] x, y, q32, r32, s32;
        logic [63:0] q, r;
        if (op[2]) begin
            x = a[31:0];
            y = b[31:0];
            if (y == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = x;
            end else if (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                q32 = x; r32 = 32'd0;
            end else if (op[0]) begin
                q32 = x / y; r32 = x % y;
            end else begin
                q32 = 32'($signed(x) / $signed(y));
                r32 = 32'($signed(x) % $signed(y));
            end
            s32 = op[1] ? r32 : q32;
            return {{32{s32[31]}}, s32};
        end
        if (b == 64'd0) begin
            q = 64'hFFFF_FFFF_FFFF_FFFF; r = a;
        end else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
            q = a; r = 64'd0;
        end else if (op[0]) begin
            q = a / b; r = a % b;
        end else begin
            q = 64'($signed(a) / $signed(b));
            r = 64'($signed(a) % $signed(b));
        end
        return op[1] ? r : q;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Every result pulse must match the model for the operation in flight
    always @(posedge i_clk) begin
        #1;
        if (o_valid === 1'b1) begin
            if (pending) chk("monitor_res", o_res, model_res);
            else chk("unexpected_valid", 64'(o_valid), 64'd0);
        end
    end

    task automatic run(input string name, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] lit, input int exp_stall);
        int  stalls;
        logic seen;
        stalls = 0;
        seen   = 1'b0;
        model_res = model(op, a, b);
        pending   = 1'b1;
        i_op = op; i_src1 = a; i_src2 = b; i_start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (o_valid) begin
                seen = 1'b1;
                break;
            end
            if (o_stall) stalls++;
            @(negedge i_clk);
            i_start = 1'b0;
        end
        i_start = 1'b0;
        if (!seen) begin
            $display("FAIL %s_timeout: got no valid expected valid within 200 cycles", name);
            total++;
        end else begin
            chk({name, "_lit"}, o_res, lit);
            chk({name, "_stall"}, 64'(stalls), 64'(exp_stall));
            chk({name, "_stall_done"}, 64'(o_stall), 64'd0);
        end
        @(negedge i_clk);
        #1;
        chk({name, "_pulse"}, 64'(o_valid), 64'd0);
        pending = 1'b0;
        @(negedge i_clk);
    endtask

    initial begin
        total = 0; passed = 0; pending = 1'b0; model_res = '0;
        i_rst = 1'b1; i_start = 1'b0; i_flush = 1'b0;
        i_op = '0; i_src1 = '0; i_src2 = '0;
        repeat (2) @(negedge i_clk);
        #1;
        chk("reset_stall", 64'(o_stall), 64'd0);
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_res", o_res, 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        run("divu_100_7", OP_DIVU, 64'd100, 64'd7, 64'd14, 66);
        run("remu_100_7", OP_REMU, 64'd100, 64'd7, 64'd2, 66);
        run("div_m7_2",   OP_DIV,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run("rem_m7_2",   OP_REM,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run("rem_100_m7", OP_REM,  64'd100, -64'sd7, 64'd2, 66);
        run("div_5_0",    OP_DIV,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run("rem_5_0",    OP_REM,  64'd5, 64'd0, 64'd5, 1);
        run("divuw_by0",  OP_DIVUW, 64'h1_8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run("div_ovf",    OP_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        run("rem_ovf",    OP_REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run("divw_ovf",   OP_DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        run("divuw_max",  OP_DIVUW, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        run("remw_9_4",   OP_REMW, 64'h1234_0000_0000_0009, 64'd4, 64'd1, 34);
        run("divw_m100_7", OP_DIVW, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 34);

        // Flush at CALC cycle 20: no result pulse, unit idle next cycle
        i_op = OP_DIVU; i_src1 = 64'hFFFF_FFFF_FFFF_FFFF; i_src2 = 64'd3; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (19) @(negedge i_clk);
        #1;
        chk("flush_pre_stall", 64'(o_stall), 64'd1);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        #1;
        chk("flush_stall", 64'(o_stall), 64'd0);
        chk("flush_valid", 64'(o_valid), 64'd0);
        @(negedge i_clk);
        #1;
        chk("flush_valid2", 64'(o_valid), 64'd0);
        run("divu_9_3", OP_DIVU, 64'd9, 64'd3, 64'd3, 66);

        // Async reset while in FIX
        i_op = OP_DIVU; i_src1 = 64'd100; i_src2 = 64'd7; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (64) @(negedge i_clk);
        #1;
        chk("fix_stall", 64'(o_stall), 64'd1);
        chk("fix_res_held", o_res, 64'd3);
        i_rst = 1'b1;
        #1;
        chk("rst_fix_stall", 64'(o_stall), 64'd0);
        chk("rst_fix_valid", 64'(o_valid), 64'd0);
        chk("rst_fix_res", o_res, 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_no_valid", 64'(o_valid), 64'd0);

        run("divu_after_rst", OP_DIVU, 64'd1000, 64'd10, 64'd100, 66);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/exu_div.md
# exu_div

Iterative RV64M divide/remainder unit in the execute stage. It consumes the forwarded rs1/rs2 operands delivered to ID/EX by the bypass network and computes DIV/DIVU/REM/REMU and their W forms, one quotient bit per cycle. While it works, it holds the pipeline through a stall output, then presents the result for one cycle so the result can enter the EX/LS register.

## Interface
- Parameters: none. Data width is the shared config `CPU_WIDTH` (64).
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  divide instruction present in EX with valid operands
- i_flush  in  1  synchronous kill of the in-flight operation (redirect/trap)
- i_op  in  3  [0]=unsigned, [1]=remainder, [2]=word (32-bit) variant
- i_src1  in  64  dividend (forwarded rs1)
- i_src2  in  64  divisor (forwarded rs2)
- o_stall  out  1  freeze PC, IF/ID and ID/EX; insert bubble into EX/LS
- o_valid  out  1  o_res valid this cycle (single-cycle pulse)
- o_res  out  64  quotient or remainder; W forms sign-extended from bit 31

## Operation
- The FSM has four states: IDLE, CALC, FIX, DONE.
- IDLE, i_start=1, i_flush=0: latch the op and the operands.
  - W ops use src[31:0]. Signed W ops sign-extend; unsigned W ops zero-extend.
  - Signed ops store operand magnitudes, plus q_neg = sign1^sign2 and r_neg = sign1.
- Special cases are decided in IDLE and skip CALC, going directly to DONE:
  - Divisor==0: quotient = all ones (-1); remainder = dividend (W ops: low 32 bits, sign-extended).
  - Signed overflow (dividend = most-negative, divisor = -1 at the op width): quotient = dividend; remainder = 0.
- Otherwise IDLE→CALC, with the iteration counter set to N-1 (N=64, or N=32 for W ops).
- CALC performs a restoring step each cycle:
  - Shift {rem,quo} left by 1.
  - If rem >= divisor, subtract the divisor and set quo[0]=1.
  - The remainder register is N+1 bits wide so the comparison never overflows.
  - When counter==0, go to FIX; otherwise decrement the counter.
- FIX:
  - Negate the quotient if q_neg; negate the remainder if r_neg.
  - Select the quotient or the remainder per op[1].
  - W ops: sign-extend bit 31. Go to DONE.
- DONE: o_valid=1 and o_res holds the result. The next edge goes unconditionally to IDLE; i_start sampled in DONE is ignored.
- o_stall = (state==IDLE && i_start) | state==CALC | state==FIX. It is low in DONE, so the pipeline advances on the same edge the result is consumed.
- i_flush=1 in any state: go to IDLE on the next edge. If the current state is DONE, o_valid stays asserted for that cycle but the pipeline discards it. i_flush has priority over i_start.
- i_rst: state=IDLE, counter=0, and all datapath registers clear.

## Timing
- Reset values: o_stall=0 when i_start=0; o_valid=0; o_res=0.
- Counting the start edge as edge 0:
  - 64-bit op: CALC runs over edges 1..64, FIX is the cycle after edge 64, and DONE (o_valid=1) is the cycle after edge 65. That is 66 cycles from the start edge; o_stall is high for 66 cycles.
  - W op: DONE is the cycle after edge 33 (34 cycles).
  - Special case: DONE is the cycle after edge 0; o_stall is high for 1 cycle.
- o_stall depends combinationally on i_start in IDLE; it has no combinational path from i_src*.
- Back-to-back divides: the second i_start is accepted in the IDLE cycle after DONE. There is no idle bubble inside the unit.
- Async reset mid-CALC aborts immediately. o_valid is never asserted for the aborted op.

## Test plan
- Operands 100 / 7: DIVU → o_res=14; REMU → o_res=2. Each has exactly 66 stall cycles and a single o_valid pulse.
- Operands -7 / 2 signed: DIV → 0xFFFF_FFFF_FFFF_FFFD (-3); REM → 0xFFFF_FFFF_FFFF_FFFF (-1).
- Divide by zero:
  - DIV 5/0 → all ones.
  - REM 5/0 → 5.
  - DIVUW src1=0x1_8000_0000, /0 → 0xFFFF_FFFF_FFFF_FFFF.
  - Each has a 1-cycle stall.
- Overflow:
  - DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000; REM → 0.
  - DIVW 0x8000_0000 / 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- W variants:
  - DIVUW 0xFFFF_FFFF / 1 → 0xFFFF_FFFF_FFFF_FFFF (sign-extended), with 34 stall cycles.
  - REMW src1=0x1234_0000_0000_0009, src2=4 → 1.
- Flush and reset:
  - Assert i_flush at cycle 20 of CALC → IDLE next edge, o_stall low, no o_valid.
  - A new DIVU 9/3 issued immediately afterwards returns 3.
  - Async i_rst mid-FIX → all outputs 0 at once.
